// File: rtl/pad_out_seq.sv
// rtl/pad_out_seq.sv - core-to-pad output sequencer with turnaround and contention check
//
// Optional feature macro: PAD_OUT_SEQ_SYNC_EN (2-flop synchronizer on p2c readback)
//
// Ports:
//   clk          in   clock, all state changes on rising edge
//   rst          in   synchronous active-high reset
//   c2p          in   core data to drive on the pad
//   c2p_en       in   core request to drive the pad (level)
//   pad_out      out  registered data to pad output driver
//   pad_oe       out  registered output enable to pad driver
//   p2c          in   pad readback from input pad cell
//   drive_active out  high while driving (same as pad_oe)
//   contention   out  sticky readback-mismatch flag
//   err_cnt      out  saturating mismatch cycle count
//   clear_err    in   clears contention and err_cnt
module pad_out_seq #(
   parameter int unsigned TURN_CYCLES   = 2,
   parameter int unsigned SETTLE_CYCLES = 1,
   parameter int unsigned CNT_W         = 4,
   parameter int unsigned ERR_W         = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             c2p,
   input  logic             c2p_en,
   output logic             pad_out,
   output logic             pad_oe,
   input  logic             p2c,
   output logic             drive_active,
   output logic             contention,
   output logic [ERR_W-1:0] err_cnt,
   input  logic             clear_err
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      TURN_ON  = 2'd1,
      DRIVE    = 2'd2,
      TURN_OFF = 2'd3
   } state_t;

`ifdef PAD_OUT_SEQ_SYNC_EN
   // Two extra settle steps cover the synchronizer latency; the counter is
   // widened so SETTLE_CYCLES+2 always fits.
   localparam int unsigned SET_W      = CNT_W + 2;
   localparam int unsigned SETTLE_MAX = SETTLE_CYCLES + 2;
`else
   localparam int unsigned SET_W      = CNT_W;
   localparam int unsigned SETTLE_MAX = SETTLE_CYCLES;
`endif

   localparam logic [CNT_W-1:0] TURN_LOAD = CNT_W'(TURN_CYCLES - 1);
   localparam logic [SET_W-1:0] SET_LIM   = SET_W'(SETTLE_MAX);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   turn_cnt_q, turn_cnt_d;
   logic [SET_W-1:0]   settle_q, settle_d;
   logic               pad_out_q, pad_out_d;
   logic               pad_oe_q, pad_oe_d;
   logic               contention_q, contention_d;
   logic [ERR_W-1:0]   err_cnt_q, err_cnt_d;
   logic               p2c_cmp;
   logic               mismatch;

`ifdef PAD_OUT_SEQ_SYNC_EN
   logic p2c_s1_q, p2c_s2_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         p2c_s1_q <= 1'b0;
         p2c_s2_q <= 1'b0;
      end else begin
         p2c_s1_q <= p2c;
         p2c_s2_q <= p2c_s1_q;
      end
   end

   assign p2c_cmp = p2c_s2_q;
`else
   assign p2c_cmp = p2c;
`endif

   always_comb begin
      state_d    = state_q;
      turn_cnt_d = turn_cnt_q;
      unique case (state_q)
         IDLE: begin
            if (c2p_en) begin
               state_d    = TURN_ON;
               turn_cnt_d = TURN_LOAD;
            end
         end
         TURN_ON: begin
            // Dropping the request aborts straight to IDLE: pad_oe never rose.
            if (!c2p_en) begin
               state_d = IDLE;
            end else if (turn_cnt_q == '0) begin
               state_d = DRIVE;
            end else begin
               turn_cnt_d = turn_cnt_q - CNT_W'(1);
            end
         end
         DRIVE: begin
            if (!c2p_en) begin
               state_d    = TURN_OFF;
               turn_cnt_d = TURN_LOAD;
            end
         end
         TURN_OFF: begin
            // Request ignored here; it is picked up again from IDLE.
            if (turn_cnt_q == '0) begin
               state_d = IDLE;
            end else begin
               turn_cnt_d = turn_cnt_q - CNT_W'(1);
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      // Data tracks the core during TURN_ON so it is valid when pad_oe rises.
      pad_out_d = ((state_d == TURN_ON) || (state_d == DRIVE)) ? c2p : pad_out_q;
      pad_oe_d  = (state_d == DRIVE);

      settle_d = settle_q;
      if (((state_q != DRIVE) && (state_d == DRIVE)) || (pad_out_d != pad_out_q)) begin
         settle_d = '0;
      end else if ((state_q == DRIVE) && (settle_q != SET_LIM)) begin
         settle_d = settle_q + SET_W'(1);
      end

      mismatch = (state_q == DRIVE) && (settle_q == SET_LIM) && (p2c_cmp != pad_out_q);

      contention_d = contention_q;
      err_cnt_d    = err_cnt_q;
      if (mismatch) begin
         // A mismatch in the clearing cycle restarts the count at one.
         contention_d = 1'b1;
         if (clear_err) begin
            err_cnt_d = ERR_W'(1);
         end else if (err_cnt_q != '1) begin
            err_cnt_d = err_cnt_q + ERR_W'(1);
         end
      end else if (clear_err) begin
         contention_d = 1'b0;
         err_cnt_d    = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         turn_cnt_q   <= '0;
         settle_q     <= '0;
         pad_out_q    <= 1'b0;
         pad_oe_q     <= 1'b0;
         contention_q <= 1'b0;
         err_cnt_q    <= '0;
      end else begin
         state_q      <= state_d;
         turn_cnt_q   <= turn_cnt_d;
         settle_q     <= settle_d;
         pad_out_q    <= pad_out_d;
         pad_oe_q     <= pad_oe_d;
         contention_q <= contention_d;
         err_cnt_q    <= err_cnt_d;
      end
   end

   assign pad_out      = pad_out_q;
   assign pad_oe       = pad_oe_q;
   assign drive_active = pad_oe_q;
   assign contention   = contention_q;
   assign err_cnt      = err_cnt_q;

endmodule

// File: tb/tb_pad_out_seq.sv
// tb/tb_pad_out_seq.sv - self-checking bench for pad_out_seq
module tb_pad_out_seq;

   logic       clk = 1'b0;
   logic       rst;
   logic       c2p;
   logic       c2p_en;
   logic       pad_out;
   logic       pad_oe;
   logic       p2c;
   logic       drive_active;
   logic       contention;
   logic [7:0] err_cnt;
   logic       clear_err;

   int n_assert = 0;
   int n_fail   = 0;

   typedef struct {
      string      tag;
      logic       oe;
      logic       out;
      logic       cont;
      logic [7:0] err;
   } exp_t;

   exp_t sb[$];

   pad_out_seq #(
      .TURN_CYCLES  (2),
      .SETTLE_CYCLES(1),
      .CNT_W        (4),
      .ERR_W        (8)
   ) dut (
      .clk         (clk),
      .rst         (rst),
      .c2p         (c2p),
      .c2p_en      (c2p_en),
      .pad_out     (pad_out),
      .pad_oe      (pad_oe),
      .p2c         (p2c),
      .drive_active(drive_active),
      .contention  (contention),
      .err_cnt     (err_cnt),
      .clear_err   (clear_err)
   );

   always #5 clk = ~clk;

   task automatic cmp(input string tag, input string what, input logic [7:0] obs, input logic [7:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s.%s: observed %0h expected %0h", tag, what, obs, exp);
      end
   endtask

   // Push the expectation for the coming edge, clock it, then pop and compare.
   task automatic tick(input string tag, input logic e_oe, input logic e_out,
                       input logic e_cont, input logic [7:0] e_err);
      exp_t e;
      e.tag  = tag;
      e.oe   = e_oe;
      e.out  = e_out;
      e.cont = e_cont;
      e.err  = e_err;
      sb.push_back(e);
      @(posedge clk);
      #1;
      e = sb.pop_front();
      cmp(e.tag, "pad_oe", {7'd0, pad_oe}, {7'd0, e.oe});
      cmp(e.tag, "drive_active", {7'd0, drive_active}, {7'd0, e.oe});
      cmp(e.tag, "pad_out", {7'd0, pad_out}, {7'd0, e.out});
      cmp(e.tag, "contention", {7'd0, contention}, {7'd0, e.cont});
      cmp(e.tag, "err_cnt", err_cnt, e.err);
   endtask

   initial begin
      logic cur;
      int   ev;

      rst = 1'b1; c2p = 1'b0; c2p_en = 1'b0; p2c = 1'b0; clear_err = 1'b0;
      #2;
      tick("reset", 0, 0, 0, 8'd0);
      rst = 1'b0;
      tick("idle", 0, 0, 0, 8'd0);

      // Turn-on timing
      c2p = 1'b1; c2p_en = 1'b1; p2c = 1'b1;
      tick("on_e0", 0, 1, 0, 8'd0);
      tick("on_e1", 0, 1, 0, 8'd0);
      tick("on_e2", 1, 1, 0, 8'd0);
      tick("settle", 1, 1, 0, 8'd0);

      // Contention accumulate, then clear
      p2c = 1'b0;
      tick("cont1", 1, 1, 1, 8'd1);
      tick("cont2", 1, 1, 1, 8'd2);
      tick("cont3", 1, 1, 1, 8'd3);
      p2c = 1'b1; clear_err = 1'b1;
      tick("clear", 1, 1, 0, 8'd0);
      clear_err = 1'b0;
      tick("cleared", 1, 1, 0, 8'd0);

      // Mismatch in the clear cycle wins
      p2c = 1'b0;
      tick("acc1", 1, 1, 1, 8'd1);
      tick("acc2", 1, 1, 1, 8'd2);
      clear_err = 1'b1;
      tick("clr_race", 1, 1, 1, 8'd1);
      p2c = 1'b1;
      tick("clr_ok", 1, 1, 0, 8'd0);
      clear_err = 1'b0;

      // Settle masking: pad_out toggles each edge, readback lags a cycle
      cur = 1'b1;
      for (int i = 0; i < 8; i++) begin
         p2c = (i == 0) ? cur : ~cur;
         c2p = ~cur;
         cur = ~cur;
         tick("mask", 1, cur, 0, 8'd0);
      end
      p2c = cur;
      tick("resettle", 1, cur, 0, 8'd0);

      // Saturation
      p2c = ~cur;
      for (int i = 0; i < 300; i++) begin
         ev = (i + 1 > 255) ? 255 : i + 1;
         tick("sat", 1, cur, 1, 8'(ev));
      end

      // Reset mid-DRIVE with request still high
      p2c = 1'b1; c2p = 1'b1; rst = 1'b1;
      tick("rst_mid", 0, 0, 0, 8'd0);
      rst = 1'b0;
      tick("rst_r1", 0, 1, 0, 8'd0);
      tick("rst_r2", 0, 1, 0, 8'd0);
      tick("rst_r3", 1, 1, 0, 8'd0);
      tick("rst_drv", 1, 1, 0, 8'd0);

      // Turn-off lockout; pad_out held outside TURN_ON/DRIVE
      c2p_en = 1'b0; c2p = 1'b0;
      tick("off_F", 0, 1, 0, 8'd0);
      c2p_en = 1'b1;
      tick("off_F1", 0, 1, 0, 8'd0);
      tick("off_F2", 0, 1, 0, 8'd0);
      p2c = 1'b0;
      tick("off_F3", 0, 0, 0, 8'd0);
      tick("off_F4", 0, 0, 0, 8'd0);
      tick("off_F5", 1, 0, 0, 8'd0);
      tick("off_drv", 1, 0, 0, 8'd0);

      // Return to IDLE, then a one-cycle abort request
      c2p_en = 1'b0;
      tick("go_off0", 0, 0, 0, 8'd0);
      tick("go_off1", 0, 0, 0, 8'd0);
      tick("go_idle", 0, 0, 0, 8'd0);
      c2p = 1'b1; c2p_en = 1'b1;
      tick("abort_on", 0, 1, 0, 8'd0);
      c2p_en = 1'b0; c2p = 1'b0;
      tick("abort_idle", 0, 1, 0, 8'd0);
      tick("abort_hold", 0, 1, 0, 8'd0);
      // Abort went straight to IDLE, so a new request turns on with no lockout
      c2p = 1'b0; c2p_en = 1'b1;
      tick("re_on0", 0, 0, 0, 8'd0);
      tick("re_on1", 0, 0, 0, 8'd0);
      tick("re_on2", 1, 0, 0, 8'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/pad_out_seq.md
Name: pad_out_seq

Overview:
- Core-to-pad sequencer for a bidirectional IO pad. It is the output-direction counterpart of the input pad cell.
- Registers the core data and output enable before they reach the pad driver.
- Inserts turnaround dead cycles whenever the pad switches between driven and released, to avoid bus contention.
- Compares the value read back from the pad's input path (p2c) against the driven value and flags contention.

Parameters:
- TURN_CYCLES, 2, dead cycles before pad_oe rises and after it falls; legal range 1..(2**CNT_W)-1.
- SETTLE_CYCLES, 1, cycles after a pad_out change before readback is compared; legal range 0..(2**CNT_W)-1.
- CNT_W, 4, width of the turnaround and settle counters.
- ERR_W, 8, width of the saturating contention error counter.

Ports:
- clk  input  1  clock; all state changes on its rising edge.
- rst  input  1  reset, synchronous, active-high.
- c2p  input  1  core data to drive on the pad.
- c2p_en  input  1  core request to drive the pad; level-sensitive.
- pad_out  output  1  registered data to the pad output driver.
- pad_oe  output  1  registered output enable to the pad driver.
- p2c  input  1  pad readback from the input pad cell.
- drive_active  output  1  high while in DRIVE; identical to pad_oe.
- contention  output  1  sticky flag: readback mismatch seen while driving.
- err_cnt  output  ERR_W  saturating count of mismatch cycles.
- clear_err  input  1  clears contention and err_cnt.

Behaviour:
- Interface: one clock, clk. Reset rst is synchronous and active-high.
- Reset values (on the edge where rst=1):
  - state=IDLE; pad_oe=0; pad_out=0; drive_active=0; contention=0; err_cnt=0; counters=0.
  - rst asserted mid-operation (any state) forces these values on that edge, so pad_oe drops with no turnaround.
- FSM states: IDLE, TURN_ON, DRIVE, TURN_OFF.
- IDLE:
  - pad_oe=0.
  - c2p_en=1 sampled at edge E -> TURN_ON, turnaround counter loaded with TURN_CYCLES-1.
- TURN_ON:
  - pad_oe=0; counter decrements each cycle.
  - At counter=0 with c2p_en=1 -> DRIVE. pad_oe rises on edge E+TURN_CYCLES.
  - c2p_en=0 in any TURN_ON cycle -> IDLE on that edge; no TURN_OFF, since pad_oe never rose.
- DRIVE:
  - pad_oe=1.
  - c2p_en=0 sampled at edge F -> TURN_OFF, pad_oe=0 after F, counter loaded with TURN_CYCLES-1.
- TURN_OFF:
  - pad_oe=0; c2p_en is ignored.
  - At counter=0 -> IDLE on edge F+TURN_CYCLES.
  - A held or new c2p_en=1 is acted on in IDLE, so minimum off time is TURN_CYCLES+1 cycles.
- pad_out:
  - pad_out <= c2p on every edge while the next state is TURN_ON or DRIVE; held otherwise. Valid data is therefore present when pad_oe rises.
  - Latency from c2p to pad_out is 1 cycle.
- Settle counter:
  - Cleared on entry to DRIVE and on any edge where pad_out changes value.
  - Increments in DRIVE, saturating at SETTLE_CYCLES.
- Contention check:
  - Active when state=DRIVE, settle counter=SETTLE_CYCLES, and p2c != pad_out.
  - On such a cycle: contention <= 1 and err_cnt increments once, saturating at 2**ERR_W-1.
  - No checks occur outside DRIVE.
- clear_err:
  - Clears contention and err_cnt.
  - If a mismatch occurs in the same cycle, the mismatch wins: contention=1, err_cnt=1.
- pad_oe and pad_out come straight from flops, with no combinational path from inputs.

Optional Feature:
- Macro: PAD_OUT_SEQ_SYNC_EN.
- Defined:
  - p2c passes through a 2-flop synchronizer (reset to 0) before comparison.
  - The compare additionally requires the settle counter to be at or beyond SETTLE_CYCLES+2. The settle counter saturates at SETTLE_CYCLES+2, so readback latency is covered.
- Undefined: p2c is compared directly, as described in Behaviour.

Test Plan:
- Turn-on timing (TURN_CYCLES=2): after reset, c2p=1, c2p_en rises before edge 0 -> pad_oe=0 after edges 0 and 1, pad_oe=1 after edge 2; pad_out=1 from edge 0 on; drive_active mirrors pad_oe.
- Turn-off lockout: DRIVE, c2p_en drops before edge F then re-asserts at F+1 -> pad_oe=0 after F; IDLE after F+2; TURN_ON entered at F+3; pad_oe=1 after F+5.
- Abort: c2p_en high for 1 cycle from IDLE (TURN_CYCLES=2) -> TURN_ON then IDLE; pad_oe stays 0 throughout.
- Contention (SETTLE_CYCLES=1): DRIVE with pad_out=1 and p2c forced 0 for 3 cycles beginning after settle -> contention=1, err_cnt=3. Then clear_err pulsed with p2c=1 -> contention=0, err_cnt=0.
- Settle masking: toggle c2p every cycle in DRIVE with p2c following one cycle late (SETTLE_CYCLES=1) -> contention stays 0. Also saturation: force mismatch for 300 cycles with ERR_W=8 -> err_cnt=255.
- Reset mid-DRIVE: rst=1 for one edge -> pad_oe=0, pad_out=0, contention=0, err_cnt=0 after that edge. With c2p_en still 1, pad_oe returns TURN_CYCLES+1 edges after rst deasserts.
